mem_data_buffer: RTL and testbench
==================================

Name: mem_data_buffer

Overview:
- Parametrised successor to the single-stage memory-data register. Captures memory read data into a DEPTH-entry queue with valid/ready handshakes on both sides.
- Applies load-size extension (byte / half / word, signed or unsigned) on capture.
- Sits between data-memory read port and writeback. Decouples memory latency from pipeline stalls; supports flush on branch/exception.

Parameters:
- WIDTH, 24, datapath word width in bits; must be even and ≥16.
- DEPTH, 2, number of queue entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH+1), width of occupancy count output.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all entries.
- in_valid  input  1  memdata/in_size/in_signed valid this cycle.
- in_ready  output  1  buffer can accept an entry.
- memdata  input  WIDTH  raw memory read word.
- in_size  input  2  00 byte [7:0], 01 half [WIDTH/2-1:0], 10 word, 11 reserved (treated as word).
- in_signed  input  1  1 = sign-extend, 0 = zero-extend (ignored for word).
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head entry.
- data  output  WIDTH  extended head entry.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, all storage entries=0. Outputs: in_ready=1, out_valid=0, data=0.
- Push: occurs when in_valid && in_ready. Extended word is written at wr_ptr; wr_ptr increments mod DEPTH.
- Pop: occurs when out_valid && out_ready. rd_ptr increments mod DEPTH.
- in_ready = (count != DEPTH). It is driven from registered state only, with no combinational path from out_ready.
- out_valid = (count != 0).
- data = storage[rd_ptr]. Combinational read of the registered entry. When empty, data shows the last stale entry (0 after reset); the consumer ignores it.
- count: +1 on push only, −1 on pop only, unchanged on push and pop together.
- Latency: 1 cycle, with no bypass. A word pushed into an empty buffer at edge N is visible with out_valid=1 after edge N.
- Simultaneous push and pop:
  - When 0<count<DEPTH, both take effect.
  - When full, push cannot occur (in_ready=0). Pop frees the slot, and in_ready rises the next cycle.
  - When empty, pop cannot occur; push proceeds.
- Extension on capture:
  - byte: result = {{WIDTH-8{s&memdata[7]}}, memdata[7:0]}.
  - half: result = {{WIDTH/2{s&memdata[WIDTH/2-1]}}, memdata[WIDTH/2-1:0]}.
  - word/reserved: result = memdata.
  - Here s = in_signed.
- Pointer wrap: both pointers wrap DEPTH-1 → 0. Full and empty are distinguished by count, not by pointer comparison.
- Flush (synchronous): wr_ptr=0, rd_ptr=0, count=0 at the next edge. Flush overrides a same-cycle push and pop; neither takes effect. Storage contents are not cleared.
- Reset asserted mid-operation: state clears immediately (asynchronous), regardless of clk. Any in-flight handshake is discarded.
- in_valid held while in_ready=0: memdata must be held stable by the producer; the block does not latch it.

Test Plan:
- Reset/idle: assert rst mid-cycle with count=2 → out_valid=0, in_ready=1, count=0, data=0 without waiting for clk.
- Extension: push memdata=24'h00_00F5 for each of:
  - size=00, signed=1 → data=24'hFFFFF5.
  - size=00, signed=0 → 24'h0000F5.
  - memdata=24'h000800, size=01, signed=1 → 24'hFFF800.
  - size=10 → 24'h000800.
- Fill/backpressure (DEPTH=2): out_ready=0, push A=24'h111111 and B=24'h222222 → count=2, in_ready=0. A third word C held valid is not accepted. Raise out_ready → A popped, next cycle in_ready=1, C accepted; order out is A, B, C.
- Concurrent push/pop at count=1: push and pop the same cycle for 8 consecutive cycles with an incrementing pattern → count stays 1 and the output sequence matches the input sequence. Pointer wrap is exercised 4 times.
- Flush priority: count=2, assert flush together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, in_ready=1. The flushed word is never seen on data with out_valid=1.
- Latency: empty buffer, push at edge N with out_ready=1 → out_valid=0 before edge N and 1 after it; popped at edge N+1; count returns to 0.

Source files
------------

// File: rtl/mem_data_buffer.sv
// Memory read-data queue: captures load data with size/sign extension into a
// DEPTH-entry FIFO with valid/ready handshakes on both sides.
module mem_data_buffer #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] memdata,
    input  logic [1:0]       in_size,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned HALF  = WIDTH / 2;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;

    logic [WIDTH-1:0] storage_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push, pop;
    logic [WIDTH-1:0] ext_data;

    // Handshake status depends only on registered occupancy.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign data  = storage_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        ext_data = memdata;
        unique case (in_size)
            SizeByte: ext_data = {{(WIDTH - 8){in_signed & memdata[7]}}, memdata[7:0]};
            SizeHalf: ext_data = {{HALF{in_signed & memdata[HALF-1]}}, memdata[HALF-1:0]};
            default:  ext_data = memdata;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow gives the wrap.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flush leaves storage untouched; only the pointers are cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_q[i] <= '0;
            end
        end else if (push && !flush) begin
            storage_q[wr_ptr_q] <= ext_data;
        end
    end

endmodule

// File: tb/tb_mem_data_buffer.sv
// Directed bench for mem_data_buffer: extension table plus handshake,
// wrap, flush, latency and asynchronous-reset sequences.
module tb_mem_data_buffer;

    localparam int unsigned WIDTH = 24;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] memdata;
    logic [1:0]       in_size;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] count;

    int vectors = 0;
    int errors  = 0;

    mem_data_buffer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .memdata  (memdata),
        .in_size  (in_size),
        .in_signed(in_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data     (data),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] raw;
        logic [1:0]       size;
        logic             sgn;
        logic [WIDTH-1:0] exp;
    } ext_vec_t;

    ext_vec_t ext_tab [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        in_valid = 1'b1;
        memdata  = w;
        in_size  = 2'b10;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        ext_tab[0] = '{24'h0000F5, 2'b00, 1'b1, 24'hFFFFF5};
        ext_tab[1] = '{24'h0000F5, 2'b00, 1'b0, 24'h0000F5};
        ext_tab[2] = '{24'h000800, 2'b01, 1'b1, 24'hFFF800};
        ext_tab[3] = '{24'h000800, 2'b10, 1'b1, 24'h000800};
        ext_tab[4] = '{24'hABC123, 2'b01, 1'b0, 24'h000123};
        ext_tab[5] = '{24'hABC8A3, 2'b01, 1'b1, 24'hFFF8A3};
        ext_tab[6] = '{24'hABC8A3, 2'b01, 1'b0, 24'h0008A3};
        ext_tab[7] = '{24'hABCDEF, 2'b11, 1'b1, 24'hABCDEF};
        ext_tab[8] = '{24'h12347F, 2'b00, 1'b1, 24'h00007F};
        ext_tab[9] = '{24'hFEDC80, 2'b10, 1'b0, 24'hFEDC80};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        memdata   = '0;
        in_size   = 2'b10;
        in_signed = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset count", 32'(count), 32'd0);
        chk("reset data", 32'(data), 32'd0);
        rst = 1'b0;
        step();

        // Extension table: push into empty buffer, check head, then pop.
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            memdata   = ext_tab[i].raw;
            in_size   = ext_tab[i].size;
            in_signed = ext_tab[i].sgn;
            step();
            in_valid = 1'b0;
            chk($sformatf("ext[%0d] data", i), 32'(data), 32'(ext_tab[i].exp));
            chk($sformatf("ext[%0d] count", i), 32'(count), 32'd1);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk($sformatf("ext[%0d] drained", i), 32'(count), 32'd0);
        end
        in_signed = 1'b0;

        // Fill and backpressure.
        push_word(24'h111111);
        push_word(24'h222222);
        chk("full count", 32'(count), 32'd2);
        chk("full in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        memdata  = 24'h333333;
        in_size  = 2'b10;
        step();
        chk("held C not taken count", 32'(count), 32'd2);
        chk("held C head A", 32'(data), 32'h111111);
        out_ready = 1'b1;
        step();
        chk("pop A count", 32'(count), 32'd1);
        chk("pop A in_ready", 32'(in_ready), 32'd1);
        chk("head B", 32'(data), 32'h222222);
        step();
        in_valid = 1'b0;
        chk("push C pop B count", 32'(count), 32'd1);
        chk("head C", 32'(data), 32'h333333);
        step();
        out_ready = 1'b0;
        chk("drain C count", 32'(count), 32'd0);
        chk("drain C out_valid", 32'(out_valid), 32'd0);

        // Concurrent push/pop at count=1 across repeated pointer wrap.
        push_word(24'h000100);
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            memdata   = 24'(32'h101 + i);
            out_ready = 1'b1;
            chk($sformatf("conc[%0d] head", i), 32'(data), 32'h100 + i);
            step();
            chk($sformatf("conc[%0d] count", i), 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        chk("conc tail head", 32'(data), 32'h108);
        step();
        out_ready = 1'b0;
        chk("conc drained", 32'(count), 32'd0);

        // Flush overrides same-cycle push and pop.
        push_word(24'hDDDDDD);
        push_word(24'hEEEEEE);
        chk("pre-flush count", 32'(count), 32'd2);
        flush     = 1'b1;
        in_valid  = 1'b1;
        memdata   = 24'hFFFFFF;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("flush count", 32'(count), 32'd0);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        step();
        chk("post-flush out_valid", 32'(out_valid), 32'd0);

        // Latency: visible one edge after push, popped on the following edge.
        in_valid  = 1'b1;
        memdata   = 24'h5A5A5A;
        out_ready = 1'b1;
        chk("lat before edge out_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        chk("lat after edge out_valid", 32'(out_valid), 32'd1);
        chk("lat data", 32'(data), 32'h5A5A5A);
        chk("lat count", 32'(count), 32'd1);
        step();
        out_ready = 1'b0;
        chk("lat popped count", 32'(count), 32'd0);

        // Asynchronous reset mid-cycle with buffer full.
        push_word(24'h777777);
        push_word(24'h888888);
        chk("pre-rst count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        chk("async rst count", 32'(count), 32'd0);
        chk("async rst data", 32'(data), 32'd0);
        step();
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
